// File: rtl/jk_register_counter.sv
// jk_register_counter: WIDTH-bit register of per-bit JK cells with load and modulo-N up/down count.
// Latency: one clk edge from inputs to q; qd and tc are combinational from q and the current inputs.
// Backpressure: none; en=0 freezes all state, and rst overrides everything asynchronously.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active-high; q goes to RESET_VAL at once
//   en   - clock enable; 0 holds q for every mode
//   mode - 00 per-bit JK, 01 parallel load, 10 count up mod MODULUS, 11 count down mod MODULUS
//   j/k  - per-bit JK controls (mode 00)
//   d    - parallel load data (mode 01)
//   q    - register state; qd is always ~q
//   tc   - terminal count: high in the cycle whose edge will wrap the count
module jk_register_counter #(
  parameter int               WIDTH     = 4,
  parameter int               MODULUS   = 2 ** WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qd,
  output logic             tc
);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_DOWN = 2'b11;

  // MODULUS may equal 2**WIDTH, which does not fit in WIDTH bits, so all
  // range comparisons are done one bit wider.
  localparam logic [WIDTH:0] MOD_W  = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0] MOD_M1 = (WIDTH + 1)'(MODULUS - 1);

  logic [WIDTH:0]   q_ext;
  logic             at_top;     // next up-count wraps to 0
  logic             at_bottom;  // next down-count wraps to MODULUS-1
  logic [WIDTH-1:0] jk_next;
  logic [WIDTH-1:0] up_next;
  logic [WIDTH-1:0] down_next;
  logic [WIDTH-1:0] q_next;

  assign q_ext = {1'b0, q};

  // Out-of-range values (only reachable through JK or load) fall into the
  // wrap branch, so a single counting edge brings q back into range.
  assign at_top    = (q_ext >= MOD_M1);
  assign at_bottom = (q == '0) || (q_ext >= MOD_W);

  assign up_next   = at_top    ? '0                   : q + WIDTH'(1);
  assign down_next = at_bottom ? MOD_M1[WIDTH-1:0]    : q - WIDTH'(1);

  // Independent JK cell per bit: 00 hold, 01 clear, 10 set, 11 toggle.
  always_comb begin
    jk_next = q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j[i], k[i]})
        2'b00:   jk_next[i] = q[i];
        2'b01:   jk_next[i] = 1'b0;
        2'b10:   jk_next[i] = 1'b1;
        default: jk_next[i] = ~q[i];
      endcase
    end
  end

  always_comb begin
    q_next = q;
    if (en) begin
      case (mode)
        MODE_JK:   q_next = jk_next;
        MODE_LOAD: q_next = d;
        MODE_UP:   q_next = up_next;
        default:   q_next = down_next;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else begin
      q <= q_next;
    end
  end

  // qd is derived, never stored, so it cannot diverge from q (even in reset).
  assign qd = ~q;

  // Gated with ~rst: while reset is held no edge will be taken, so no wrap is pending.
  assign tc = ~rst & en &
              (((mode == MODE_UP) & at_top) | ((mode == MODE_DOWN) & at_bottom));

endmodule

// File: tb/tb_jk_register_counter.sv
module tb_jk_register_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] j, k, d;

  logic [3:0] q_a, qd_a, q_b, qd_b;
  logic [0:0] q_c, qd_c;
  logic [7:0] q_e, qd_e;
  logic       tc_a, tc_b, tc_c, tc_e;

  int checks   = 0;
  int failures = 0;

  // Per-instance reference: width, modulus, reset value, modelled state.
  int wid  [4] = '{4, 4, 1, 8};
  int modn [4] = '{16, 10, 2, 256};
  int rval [4] = '{5, 0, 0, 0};
  int mq   [4];

  always #5 clk = ~clk;

  jk_register_counter #(.WIDTH(4), .RESET_VAL(4'h5)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j[3:0]), .k(k[3:0]), .d(d[3:0]),
    .q(q_a), .qd(qd_a), .tc(tc_a));
  jk_register_counter #(.WIDTH(4), .MODULUS(10)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j[3:0]), .k(k[3:0]), .d(d[3:0]),
    .q(q_b), .qd(qd_b), .tc(tc_b));
  jk_register_counter #(.WIDTH(1)) u_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j[0:0]), .k(k[0:0]), .d(d[0:0]),
    .q(q_c), .qd(qd_c), .tc(tc_c));
  jk_register_counter #(.WIDTH(8)) u_e (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .q(q_e), .qd(qd_e), .tc(tc_e));

  // Reference next state from the behavioural rules, in plain integers.
  function automatic int ref_next(int qv, int w, int m);
    int mask, jj, kk, nv;
    mask = (1 << w) - 1;
    jj = int'(j) & mask;
    kk = int'(k) & mask;
    if (!en) return qv;
    case (mode)
      2'd0: nv = (qv & ~jj & ~kk) | (jj & ~kk) | (~qv & jj & kk);
      2'd1: nv = int'(d);
      2'd2: nv = (qv >= m - 1) ? 0 : qv + 1;
      default: nv = (qv == 0 || qv >= m) ? m - 1 : qv - 1;
    endcase
    return nv & mask;
  endfunction

  function automatic int ref_tc(int qv, int m);
    if (rst || !en) return 0;
    if (mode == 2'd2) return (qv >= m - 1) ? 1 : 0;
    if (mode == 2'd3) return (qv == 0 || qv >= m) ? 1 : 0;
    return 0;
  endfunction

  function automatic logic [31:0] obs_q(int i);
    case (i)
      0: return {28'b0, q_a};
      1: return {28'b0, q_b};
      2: return {31'b0, q_c};
      default: return {24'b0, q_e};
    endcase
  endfunction

  function automatic logic [31:0] obs_qd(int i);
    case (i)
      0: return {28'b0, qd_a};
      1: return {28'b0, qd_b};
      2: return {31'b0, qd_c};
      default: return {24'b0, qd_e};
    endcase
  endfunction

  function automatic logic [31:0] obs_tc(int i);
    case (i)
      0: return {31'b0, tc_a};
      1: return {31'b0, tc_b};
      2: return {31'b0, tc_c};
      default: return {31'b0, tc_e};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      int mask;
      mask = (1 << wid[i]) - 1;
      check($sformatf("%s/q%0d", tag, i),  obs_q(i),  32'(mq[i]));
      check($sformatf("%s/qd%0d", tag, i), obs_qd(i), 32'(~mq[i] & mask));
      check($sformatf("%s/tc%0d", tag, i), obs_tc(i), 32'(ref_tc(mq[i], modn[i])));
    end
  endtask

  // Advance the model with the inputs in force, take one edge, compare just after it.
  task automatic step(input string tag);
    for (int i = 0; i < 4; i++) mq[i] = ref_next(mq[i], wid[i], modn[i]);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Pulse reset between edges and check it acts without a clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) mq[i] = rval[i];
    check_all({tag, "_in"});
    rst = 1'b0;
    #1;
    check_all({tag, "_out"});
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; j = '0; k = '0; d = '0;
    #2;
    for (int i = 0; i < 4; i++) mq[i] = rval[i];
    check_all("reset");
    check("reset_val_a", {28'b0, q_a}, 32'd5);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("reset_rel");

    // Per-bit JK from 0000 with j=1010, k=0110: b3 set, b2 clear, b1 toggle, b0 hold.
    en = 1'b1; mode = 2'b01; d = 8'h00;
    step("t1_clr");
    mode = 2'b00; j = 8'b0000_1010; k = 8'b0000_0110;
    step("t1_e1");
    check("t1_q_1010", {28'b0, q_a}, 32'b1010);
    step("t1_e2");
    check("t1_q_1000", {28'b0, q_a}, 32'b1000);

    // Parallel load, then hold with en=0.
    mode = 2'b01; d = 8'b0000_1011;
    step("t2_ld");
    check("t2_q", {28'b0, q_a}, 32'b1011);
    check("t2_qd", {28'b0, qd_a}, 32'b0100);
    en = 1'b0; d = 8'h00;
    for (int n = 0; n < 3; n++) step("t2_hold");
    check("t2_held", {28'b0, q_a}, 32'b1011);

    // Modulo-10 up count from reset, 12 edges.
    do_reset("t3_rst");
    en = 1'b1; mode = 2'b10;
    for (int n = 0; n < 12; n++) begin
      step("t3_up");
      check("t3_qb", {28'b0, q_b}, 32'((n + 1) % 10));
      check("t3_tcb", {31'b0, tc_b}, 32'(((n + 1) % 10) == 9));
    end

    // Modulo-10 down count, then out-of-range recovery both directions.
    mode = 2'b01; d = 8'h00;
    step("t4_clr");
    mode = 2'b11;
    for (int n = 0; n < 3; n++) begin
      step("t4_dn");
      check("t4_qb", {28'b0, q_b}, 32'(9 - n));
    end
    mode = 2'b01; d = 8'b0000_1110;
    step("t4_ld14a");
    mode = 2'b11;
    step("t4_rec_dn");
    check("t4_rec_dn_q", {28'b0, q_b}, 32'd9);
    mode = 2'b01;
    step("t4_ld14b");
    check("t4_tc_load", {31'b0, tc_b}, 32'd0);
    mode = 2'b10;
    step("t4_rec_up");
    check("t4_rec_up_q", {28'b0, q_b}, 32'd0);

    // Reset mid-count acts immediately; counting resumes from RESET_VAL.
    mode = 2'b01; d = 8'h04;
    step("t5_ld4");
    mode = 2'b10;
    step("t5_up5");
    check("t5_q5", {28'b0, q_b}, 32'd5);
    rst = 1'b1;
    #1;
    check("t5_rst_qb", {28'b0, q_b}, 32'd0);
    check("t5_rst_qa", {28'b0, q_a}, 32'd5);
    check("t5_rst_tc", {31'b0, tc_b}, 32'd0);
    for (int i = 0; i < 4; i++) mq[i] = rval[i];
    check_all("t5_rst");
    rst = 1'b0;
    step("t5_resume");
    check("t5_resume_qb", {28'b0, q_b}, 32'd1);
    check("t5_resume_qa", {28'b0, q_a}, 32'd6);

    // WIDTH=1 toggles; WIDTH=8 default-modulus wrap 255 -> 0.
    do_reset("t6_rst");
    mode = 2'b00; j = 8'hFF; k = 8'hFF;
    step("t6_tg1");
    check("t6_w1_1", {31'b0, q_c}, 32'd1);
    step("t6_tg0");
    check("t6_w1_0", {31'b0, q_c}, 32'd0);
    mode = 2'b01; d = 8'd254;
    step("t6_ld254");
    mode = 2'b10;
    step("t6_up255");
    check("t6_w8_255", {24'b0, q_e}, 32'd255);
    check("t6_w8_tc", {31'b0, tc_e}, 32'd1);
    step("t6_wrap");
    check("t6_w8_0", {24'b0, q_e}, 32'd0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset("rnd_rst");
      end else begin
        en   = ($urandom_range(0, 3) != 0);
        mode = 2'($urandom_range(0, 3));
        j    = 8'($urandom);
        k    = 8'($urandom);
        d    = 8'($urandom);
        step("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
